npu_intranet_mover: RTL and testbench

- Responder for the controller's intranet start/end handshake.
- On a start pulse, it reads int32 accumulator words from the O-buffer banks and requantizes each to int8.
- It packs four int8 results into one 32-bit word and writes that word into the matching A-buffer bank.
- When the transfer is complete it returns a one-cycle end pulse. This closes the out2act loop between the O buffer and the A buffer.

---
 rtl/npu_pkg.sv | 16 +
 rtl/npu_requant.sv | 26 ++
 rtl/npu_intranet_mover.sv | 147 ++++++++++++++
 tb/tb_npu_intranet_mover.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared constants and types for the NPU intranet mover and its requantizer.
// Lane count, activation/accumulator widths, read latency and the mover FSM states.
package npu_pkg;
    localparam int INTRA_LANES = 4;
    localparam int LANE_W      = 2;
    localparam int ACT_WIDTH   = 8;
    localparam int ACC_WIDTH   = 32;
    localparam int RD_LAT      = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } intra_state_e;
endpackage

// File: rtl/npu_requant.sv
// Combinational requantizer: arithmetic shift, optional ReLU, saturate int32 to int8.
// Shared with the SIMD path, so it carries no state.
module npu_requant
    import npu_pkg::*;
(
    input  logic [ACC_WIDTH-1:0] acc_i,
    input  logic [4:0]           shift_i,
    input  logic                 relu_en_i,
    output logic [ACT_WIDTH-1:0] act_o
);
    logic signed [ACC_WIDTH-1:0] shifted;

    always_comb begin
        shifted = $signed(acc_i) >>> shift_i;
        act_o   = '0;
        if (relu_en_i && (shifted < 32'sd0)) begin
            act_o = '0;
        end else if (shifted > 32'sd127) begin
            act_o = 8'h7f;
        end else if (shifted < -32'sd128) begin
            act_o = 8'h80;
        end else begin
            act_o = shifted[ACT_WIDTH-1:0];
        end
    end
endmodule

// File: rtl/npu_intranet_mover.sv
// Moves int32 accumulators from the O-buffer banks into the A-buffer banks as packed int8x4,
// answering the controller's intranet start/end handshake.
module npu_intranet_mover
    import npu_pkg::*;
#(
    parameter int ARRAY_N    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    localparam int IDX_W     = (ARRAY_N > 1) ? $clog2(ARRAY_N) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  intranet_on_i,
    input  logic                  intra_sig_start_i,
    input  logic [ADDR_WIDTH-1:0] intra_o_base_addr_i,
    input  logic [ADDR_WIDTH-1:0] intra_a_base_addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic [4:0]            shift_i,
    input  logic                  relu_en_i,
    output logic                  intra_sig_end_o,
    output logic                  busy_o,
    output logic                  o_rd_en_o,
    output logic [IDX_W-1:0]      o_ram_idx_o,
    output logic [ADDR_WIDTH-1:0] o_read_addr_o,
    input  logic [31:0]           data_in_o_bram_i,
    output logic [31:0]           a_ram_w_data_o,
    output logic [ADDR_WIDTH-1:0] a_ram_w_addr_o,
    output logic [ARRAY_N-1:0]    a_ram_w_en_o
);
    // Handshake: a one-cycle start is taken only in IDLE with intranet_on_i high (otherwise
    // dropped); busy_o is high from the cycle after acceptance through the one-cycle end pulse.
    intra_state_e state, state_nxt;

    logic [ADDR_WIDTH-1:0] o_base_q, a_base_q;
    logic [LEN_WIDTH-1:0]  len_q, word_q, rd_word_q;
    logic [4:0]            shift_q;
    logic                  relu_q;
    logic [IDX_W-1:0]      bank_q, rd_bank_q;
    logic [LANE_W-1:0]     lane_q, rd_lane_q;
    logic                  drain_q, rd_vld_q;
    logic [23:0]           pack_q;
    logic [ACT_WIDTH-1:0]  act;
    logic                  accept, last_lane, last_word, last_rd;

    assign accept    = (state == ST_IDLE) && intranet_on_i && intra_sig_start_i;
    assign last_lane = (lane_q == LANE_W'(INTRA_LANES - 1));
    assign last_word = (word_q == len_q - LEN_WIDTH'(1));
    assign last_rd   = last_lane && last_word && (bank_q == IDX_W'(ARRAY_N - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (accept) state_nxt = (len_i == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (last_rd) state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_q) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_rd_en_o       = (state == ST_RUN);
        o_ram_idx_o     = o_rd_en_o ? bank_q : '0;
        o_read_addr_o   = o_rd_en_o ? (o_base_q + (ADDR_WIDTH'(word_q) << 2) + ADDR_WIDTH'(lane_q)) : '0;
        intra_sig_end_o = (state == ST_DONE);
        busy_o          = (state != ST_IDLE);
    end

    // Configuration latch and bank/word/lane read counters (lane innermost, bank outermost).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            o_base_q <= '0;
            a_base_q <= '0;
            len_q    <= '0;
            shift_q  <= '0;
            relu_q   <= 1'b0;
            bank_q   <= '0;
            word_q   <= '0;
            lane_q   <= '0;
            drain_q  <= 1'b0;
        end else begin
            if (accept) begin
                o_base_q <= intra_o_base_addr_i;
                a_base_q <= intra_a_base_addr_i;
                len_q    <= len_i;
                shift_q  <= shift_i;
                relu_q   <= relu_en_i;
                bank_q   <= '0;
                word_q   <= '0;
                lane_q   <= '0;
            end else if (state == ST_RUN) begin
                lane_q <= lane_q + 1'b1;
                if (last_lane) begin
                    if (last_word) begin
                        word_q <= '0;
                        bank_q <= bank_q + 1'b1;
                    end else begin
                        word_q <= word_q + 1'b1;
                    end
                end
            end
            drain_q <= (state == ST_DRAIN) ? ~drain_q : 1'b0;
        end
    end

    npu_requant u_requant (
        .acc_i     (data_in_o_bram_i),
        .shift_i   (shift_q),
        .relu_en_i (relu_q),
        .act_o     (act)
    );

    // Read-return pipeline: tags follow each read by one cycle to meet its data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_vld_q       <= 1'b0;
            rd_bank_q      <= '0;
            rd_word_q      <= '0;
            rd_lane_q      <= '0;
            pack_q         <= '0;
            a_ram_w_data_o <= '0;
            a_ram_w_addr_o <= '0;
            a_ram_w_en_o   <= '0;
        end else begin
            rd_vld_q     <= o_rd_en_o;
            rd_bank_q    <= bank_q;
            rd_word_q    <= word_q;
            rd_lane_q    <= lane_q;
            a_ram_w_en_o <= '0;
            if (rd_vld_q) begin
                for (int i = 0; i < INTRA_LANES - 1; i++) begin
                    if (rd_lane_q == LANE_W'(i)) pack_q[i*ACT_WIDTH +: ACT_WIDTH] <= act;
                end
                if (rd_lane_q == LANE_W'(INTRA_LANES - 1)) begin
                    a_ram_w_en_o   <= ARRAY_N'(1) << rd_bank_q;
                    a_ram_w_addr_o <= a_base_q + ADDR_WIDTH'(rd_word_q);
                    a_ram_w_data_o <= {act, pack_q};
                end
            end
        end
    end
endmodule

// File: tb/tb_npu_intranet_mover.sv
// Self-checking bench for npu_intranet_mover: O-buffer model, read/write scoreboard queues,
// per-scenario tasks for reset, packing, requantization, zero length, drops, abort and wrap.
module tb_npu_intranet_mover;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        intranet_on = 1'b0;
    logic        start = 1'b0;
    logic [31:0] o_base = '0, a_base = '0;
    logic [15:0] len = '0;
    logic [4:0]  shift = '0;
    logic        relu = 1'b0;
    logic        end_o, busy_o, rd_en;
    logic [1:0]  ram_idx;
    logic [31:0] rd_addr, data_in = '0, w_data, w_addr;
    logic [N-1:0] w_en;

    npu_intranet_mover #(.ARRAY_N(N), .ADDR_WIDTH(32), .LEN_WIDTH(16)) dut (
        .clk_i(clk), .rst_i(rst), .intranet_on_i(intranet_on), .intra_sig_start_i(start),
        .intra_o_base_addr_i(o_base), .intra_a_base_addr_i(a_base), .len_i(len),
        .shift_i(shift), .relu_en_i(relu), .intra_sig_end_o(end_o), .busy_o(busy_o),
        .o_rd_en_o(rd_en), .o_ram_idx_o(ram_idx), .o_read_addr_o(rd_addr),
        .data_in_o_bram_i(data_in), .a_ram_w_data_o(w_data), .a_ram_w_addr_o(w_addr),
        .a_ram_w_en_o(w_en)
    );

    // ---------------- clock / reset / cycle counter ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- O-buffer model (1-cycle read latency) ----------------
    logic [31:0] odata [N][16];
    logic [31:0] cur_ob = '0;
    logic [31:0] rd_off;
    assign rd_off = rd_addr - cur_ob;
    always @(posedge clk) if (rd_en) data_in <= odata[ram_idx][rd_off[3:0]];

    // ---------------- scoreboard ----------------
    logic [33:0] exp_rd_q[$];
    logic [67:0] exp_wr_q[$];
    logic [31:0] wr_log[$];
    logic [33:0] exp_rd;
    logic [67:0] exp_wr;
    int n_vec = 0, n_err = 0;
    int start_cyc = 0, end_cnt = 0, end_rel = 0, busy_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (rd_en) begin
                n_vec++;
                if (exp_rd_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rd_unexpected got idx=%0d addr=%h want no read", ram_idx, rd_addr);
                end else begin
                    exp_rd = exp_rd_q.pop_front();
                    if ({ram_idx, rd_addr} !== exp_rd) begin
                        n_err++;
                        $display("FAIL rd_seq got idx=%0d addr=%h want idx=%0d addr=%h",
                                 ram_idx, rd_addr, exp_rd[33:32], exp_rd[31:0]);
                    end
                end
            end
            if (w_en !== '0) begin
                n_vec++;
                wr_log.push_back(w_data);
                if (exp_wr_q.size() == 0) begin
                    n_err++;
                    $display("FAIL wr_unexpected got en=%b addr=%h data=%h want no write", w_en, w_addr, w_data);
                end else begin
                    exp_wr = exp_wr_q.pop_front();
                    if ({w_en, w_addr, w_data} !== exp_wr) begin
                        n_err++;
                        $display("FAIL wr_seq got en=%b addr=%h data=%h want en=%b addr=%h data=%h",
                                 w_en, w_addr, w_data, exp_wr[67:64], exp_wr[63:32], exp_wr[31:0]);
                    end
                end
            end
            if (busy_o) busy_cnt++;
            if (end_o) begin
                end_cnt++;
                end_rel = cyc - start_cyc;
            end
        end
    end

    function automatic logic [7:0] ref_q(input logic [31:0] d, input int sh, input bit rl);
        int y;
        y = int'($signed(d)) >>> sh;
        if (rl && y < 0) y = 0;
        if (y > 127) y = 127;
        if (y < -128) y = -128;
        return y[7:0];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic fill_rand();
        for (int b = 0; b < N; b++)
            for (int k = 0; k < 16; k++) odata[b][k] = $urandom_range(0, 32'hffff_ffff);
    endtask

    task automatic start_xfer(input logic [31:0] ob, input logic [31:0] ab, input logic [15:0] ln,
                              input logic [4:0] sh, input bit rl, input bit on, input bit accepted);
        logic [31:0] pk, a;
        @(posedge clk); #2;
        o_base = ob; a_base = ab; len = ln; shift = sh; relu = rl; intranet_on = on; start = 1'b1;
        start_cyc = cyc;
        busy_cnt = 0;
        if (accepted) begin
            cur_ob = ob;
            wr_log.delete();
            for (int b = 0; b < N; b++)
                for (int w = 0; w < int'(ln); w++) begin
                    pk = '0;
                    for (int l = 0; l < 4; l++) begin
                        a = ob + 32'(4 * w + l);
                        exp_rd_q.push_back({2'(b), a});
                        pk[8*l +: 8] = ref_q(odata[b][4*w+l], int'(sh), rl);
                    end
                    exp_wr_q.push_back({4'(1 << b), ab + 32'(w), pk});
                end
        end
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_end(input int exp_rel, input int tail);
        int base, t;
        base = end_cnt;
        t = 0;
        while (end_cnt == base && t < 300) begin
            @(negedge clk); #1;
            t++;
        end
        n_vec++;
        if (end_cnt == base) begin
            n_err++;
            $display("FAIL end_timeout got no end pulse want one at cycle %0d", exp_rel);
        end else if (end_rel != exp_rel) begin
            n_err++;
            $display("FAIL end_cycle got %0d want %0d", end_rel, exp_rel);
        end
        repeat (tail) @(negedge clk);
        #1;
        n_vec++;
        if (end_cnt != base + 1 || exp_rd_q.size() != 0 || exp_wr_q.size() != 0) begin
            n_err++;
            $display("FAIL xfer_tail got ends=%0d rd_left=%0d wr_left=%0d want ends=1 rd_left=0 wr_left=0",
                     end_cnt - base, exp_rd_q.size(), exp_wr_q.size());
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) @(posedge clk);
        #2;
        n_vec++;
        if ({end_o, busy_o, rd_en, ram_idx, rd_addr, w_data, w_addr, w_en} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got end=%b busy=%b rd=%b wen=%b want all 0", end_o, busy_o, rd_en, w_en);
        end
        rst = 1'b0;
        @(negedge clk); #1;
        n_vec++;
        if ({end_o, busy_o, rd_en, w_en} !== '0) begin
            n_err++;
            $display("FAIL idle_outputs got end=%b busy=%b rd=%b wen=%b want all 0", end_o, busy_o, rd_en, w_en);
        end
    endtask

    task automatic test_basic_pack();
        fill_rand();
        odata[0][0] = 32'd1; odata[0][1] = -32'sd2; odata[0][2] = 32'd127; odata[0][3] = 32'd200;
        start_xfer(32'h0000_0100, 32'h0000_0040, 16'd1, 5'd0, 1'b0, 1'b1, 1'b1);
        wait_end(19, 4);
        n_vec++;
        if (wr_log.size() != 4 || wr_log[0] !== 32'h7F7F_FE01) begin
            n_err++;
            $display("FAIL basic_pack got writes=%0d first=%h want writes=4 first=7f7ffe01",
                     wr_log.size(), (wr_log.size() > 0) ? wr_log[0] : 32'h0);
        end
        n_vec++;
        if (busy_cnt != 19) begin
            n_err++;
            $display("FAIL basic_busy got %0d cycles want 19", busy_cnt);
        end
    endtask

    task automatic test_requant_relu();
        fill_rand();
        odata[0][0] = -32'sd64; odata[0][1] = 32'd256; odata[0][2] = 32'd2047; odata[0][3] = -32'sd1;
        start_xfer(32'h0000_2000, 32'h0000_0300, 16'd1, 5'd4, 1'b1, 1'b1, 1'b1);
        wait_end(19, 4);
        n_vec++;
        if (wr_log.size() == 0 || wr_log[0] !== 32'h007F_1000) begin
            n_err++;
            $display("FAIL relu_pack got %h want 007f1000", (wr_log.size() > 0) ? wr_log[0] : 32'h0);
        end
    endtask

    task automatic test_random_len2();
        fill_rand();
        start_xfer($urandom_range(0, 32'hffff), $urandom_range(0, 32'hffff), 16'd2,
                   5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b1, 1'b1);
        wait_end(35, 4);
    endtask

    task automatic test_zero_len();
        start_xfer(32'h10, 32'h20, 16'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        wait_end(1, 4);
        n_vec++;
        if (busy_cnt != 1) begin
            n_err++;
            $display("FAIL zero_len_busy got %0d cycles want 1", busy_cnt);
        end
    endtask

    task automatic test_ignored_start();
        int base;
        fill_rand();
        start_xfer(32'h0000_0400, 32'h0000_0500, 16'd2, 5'd2, 1'b0, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #2;
        o_base = 32'h0000_9000; len = 16'd1; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        wait_end(35, 6);
        base = end_cnt;
        start_xfer(32'h0, 32'h0, 16'd1, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (25) @(negedge clk);
        #1;
        n_vec++;
        if (end_cnt != base || busy_cnt != 0) begin
            n_err++;
            $display("FAIL disabled_start got ends=%0d busy=%0d want ends=0 busy=0", end_cnt - base, busy_cnt);
        end
        intranet_on = 1'b1;
    endtask

    task automatic test_reset_abort();
        int base;
        fill_rand();
        start_xfer(32'h0000_0600, 32'h0000_0700, 16'd2, 5'd1, 1'b0, 1'b1, 1'b1);
        base = end_cnt;
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({end_o, busy_o, rd_en, ram_idx, rd_addr, w_data, w_addr, w_en} !== '0) begin
            n_err++;
            $display("FAIL abort_outputs got end=%b busy=%b rd=%b addr=%h wen=%b want all 0",
                     end_o, busy_o, rd_en, rd_addr, w_en);
        end
        exp_rd_q.delete();
        exp_wr_q.delete();
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        n_vec++;
        if (end_cnt != base || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL abort_no_end got ends=%0d busy=%b want ends=0 busy=0", end_cnt - base, busy_o);
        end
        fill_rand();
        start_xfer(32'h0000_0800, 32'h0000_0900, 16'd2, 5'd3, 1'b1, 1'b1, 1'b1);
        wait_end(35, 4);
    endtask

    task automatic test_addr_wrap();
        fill_rand();
        start_xfer(32'hFFFF_FFFE, 32'h0000_0010, 16'd1, 5'd0, 1'b0, 1'b1, 1'b1);
        wait_end(19, 4);
    endtask

    task automatic test_back_to_back();
        fill_rand();
        start_xfer(32'h0000_0A00, 32'h0000_0B00, 16'd1, 5'd5, 1'b0, 1'b1, 1'b1);
        wait_end(19, 0);
        start_xfer(32'h0000_0C00, 32'hFFFF_FFFF, 16'd1, 5'd0, 1'b1, 1'b1, 1'b1);
        wait_end(19, 4);
    endtask

    initial begin
        test_reset();
        test_basic_pack();
        test_requant_relu();
        test_random_len2();
        test_zero_len();
        test_ignored_start();
        test_reset_abort();
        test_addr_wrap();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got still running want finished");
        $fatal(1, "simulation time limit");
    end
endmodule
